// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/freeze sequencer for a 5-stage in-order pipeline.
//               Optional build macro HAZARD_PERF_CNT_EN adds performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_write_enable,
    input  logic        ex_branch_taken,
    input  logic        mem_busy,
    output logic        pc_write_en,
    output logic        ifid_write_en,
    output logic        ifid_flush,
    output logic        idex_write_en,
    output logic        idex_flush,
    output logic        exmem_write_en,
    output logic        mem_timeout,
    output logic [1:0]  ctrl_state
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
    output logic [31:0] perf_memwait_cnt
`endif
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FLUSH   = 2'd1,
        ST_MEMWAIT = 2'd2
    } state_t;

    localparam logic [2:0] C_FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [8:0] C_TIMEOUT      = 9'(MEM_TIMEOUT);

    state_t     r_state, w_state_nxt;
    logic [2:0] r_flush_cnt, w_flush_cnt_nxt;
    logic [7:0] r_wait_cnt, w_wait_cnt_nxt;
    logic [8:0] w_wait_inc;
    logic       r_timeout;
    logic       w_timeout_hit;
    logic       w_load_use;
    logic       w_stall_evt;
    logic       w_pc_we, w_ifid_we, w_ifid_fl, w_idex_we, w_idex_fl, w_exmem_we;

    assign w_load_use = ex_mem_read & ex_write_enable & (ex_rd != 5'd0) &
                        ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                         (id_uses_rs2 & (id_rs2 == ex_rd)));

    assign w_wait_inc = {1'b0, r_wait_cnt} + 9'd1;

    // A non-zero flush count means a flush sequence is in progress, even if it
    // was parked in MEMWAIT by a memory stall.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_timeout_hit   = 1'b0;
        w_stall_evt     = 1'b0;
        w_pc_we         = 1'b1;
        w_ifid_we       = 1'b1;
        w_ifid_fl       = 1'b0;
        w_idex_we       = 1'b1;
        w_idex_fl       = 1'b0;
        w_exmem_we      = 1'b1;
        if (mem_busy) begin
            w_pc_we        = 1'b0;
            w_ifid_we      = 1'b0;
            w_idex_we      = 1'b0;
            w_exmem_we     = 1'b0;
            w_state_nxt    = ST_MEMWAIT;
            w_wait_cnt_nxt = (r_wait_cnt == 8'hFF) ? 8'hFF : w_wait_inc[7:0];
            w_timeout_hit  = (w_wait_inc >= C_TIMEOUT);
        end else begin
            w_wait_cnt_nxt = 8'd0;
            if (ex_branch_taken) begin
                w_ifid_fl       = 1'b1;
                w_idex_fl       = 1'b1;
                w_flush_cnt_nxt = C_FLUSH_RELOAD;
                w_state_nxt     = (C_FLUSH_RELOAD != 3'd0) ? ST_FLUSH : ST_RUN;
            end else if (r_flush_cnt != 3'd0) begin
                w_ifid_fl       = 1'b1;
                w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                w_state_nxt     = (r_flush_cnt == 3'd1) ? ST_RUN : ST_FLUSH;
            end else if (w_load_use) begin
                w_pc_we     = 1'b0;
                w_ifid_we   = 1'b0;
                w_idex_fl   = 1'b1;
                w_stall_evt = 1'b1;
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_RUN;
            r_flush_cnt <= 3'd0;
            r_wait_cnt  <= 8'd0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_timeout   <= r_timeout | w_timeout_hit;
        end
    end

    // Outputs are forced inactive for the whole time reset is held low.
    assign pc_write_en    = reset & w_pc_we;
    assign ifid_write_en  = reset & w_ifid_we;
    assign ifid_flush     = reset & w_ifid_fl;
    assign idex_write_en  = reset & w_idex_we;
    assign idex_flush     = reset & w_idex_fl;
    assign exmem_write_en = reset & w_exmem_we;
    assign mem_timeout    = reset & (r_timeout | w_timeout_hit);
    assign ctrl_state     = r_state;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] r_stall_cnt, r_flush_evt_cnt, r_memwait_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt     <= 32'd0;
            r_flush_evt_cnt <= 32'd0;
            r_memwait_cnt   <= 32'd0;
        end else begin
            if (w_stall_evt) r_stall_cnt     <= r_stall_cnt + 32'd1;
            if (w_ifid_fl)   r_flush_evt_cnt <= r_flush_evt_cnt + 32'd1;
            if (mem_busy)    r_memwait_cnt   <= r_memwait_cnt + 32'd1;
        end
    end

    assign perf_stall_cnt   = r_stall_cnt;
    assign perf_flush_cnt   = r_flush_evt_cnt;
    assign perf_memwait_cnt = r_memwait_cnt;
`endif

endmodule
`default_nettype wire
